// File: rtl/feature_bank_pkg.sv
// Shared types and helpers for the banked feature-RAM read sequencer.
package feature_bank_pkg;

  localparam int NUM_BANKS_DEF  = 8;
  localparam int BANK_DEPTH_DEF = 512;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Flat feature index -> bank number (upper bits).
  function automatic int unsigned idx_bank(input int unsigned idx, input int unsigned addr_w);
    return idx >> addr_w;
  endfunction

  // Flat feature index -> in-bank word address (lower bits).
  function automatic int unsigned idx_addr(input int unsigned idx, input int unsigned addr_w);
    return idx & ((32'd1 << addr_w) - 32'd1);
  endfunction

endpackage

// File: rtl/feature_bank_sequencer_bank_mask_gen.sv
// Combinational contiguous bank mask: bits lo_bank_i..hi_bank_i set, zero latency.
module bank_mask_gen #(
  parameter int NUM_BANKS = 8,
  parameter int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic [BANK_W-1:0]    lo_bank_i,
  input  logic [BANK_W-1:0]    hi_bank_i,
  output logic [NUM_BANKS-1:0] mask_o
);

  always_comb begin
    mask_o = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      mask_o[i] = (BANK_W'(i) >= lo_bank_i) && (BANK_W'(i) <= hi_bank_i);
    end
  end

endmodule

// File: rtl/feature_bank_sequencer.sv
// Walks a feature-index range one word per cycle across the banks; first word 1 cycle after accept.
// Holds the word under rd_ready=0; FEAT_RANGE_CHECK_EN rejects stop<start with an err pulse.
module feature_bank_sequencer
  import feature_bank_pkg::*;
#(
  parameter int NUM_BANKS  = NUM_BANKS_DEF,
  parameter int BANK_DEPTH = BANK_DEPTH_DEF,
  parameter int FEAT_W     = $clog2(NUM_BANKS * BANK_DEPTH),
  parameter int ADDR_W     = $clog2(BANK_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [FEAT_W-1:0]    req_start,
  input  logic [FEAT_W-1:0]    req_stop,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [NUM_BANKS-1:0] bank_en,
  output logic [ADDR_W-1:0]    rd_addr,
  output logic                 rd_first,
  output logic                 rd_last,
  output logic                 bank_last,
  output logic [NUM_BANKS-1:0] bank_mask,
  output logic                 done,
  output logic                 err
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(BANK_DEPTH - 1);

  logic [0:0]           state_q, state_d;
  logic [BANK_W-1:0]    bank_q, bank_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [BANK_W-1:0]    stop_bank_q, stop_bank_d;
  logic [ADDR_W-1:0]    stop_addr_q, stop_addr_d;
  logic                 first_q, first_d;
  logic [NUM_BANKS-1:0] mask_q, mask_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 range_bad;
  logic [FEAT_W-1:0]    eff_stop;
  logic [BANK_W-1:0]    lo_bank, hi_bank;
  logic [NUM_BANKS-1:0] mask_new;
  logic                 is_final;

  assign range_bad = req_stop < req_start;

`ifdef FEAT_RANGE_CHECK_EN
  assign eff_stop = req_stop;
`else
  // A reversed range collapses to the single word at req_start.
  assign eff_stop = range_bad ? req_start : req_stop;
`endif

  assign lo_bank = BANK_W'(idx_bank(32'(req_start), ADDR_W));
  assign hi_bank = BANK_W'(idx_bank(32'(eff_stop), ADDR_W));

  bank_mask_gen #(
    .NUM_BANKS (NUM_BANKS),
    .BANK_W    (BANK_W)
  ) u_mask_gen (
    .lo_bank_i (lo_bank),
    .hi_bank_i (hi_bank),
    .mask_o    (mask_new)
  );

  assign is_final  = (bank_q == stop_bank_q) && (addr_q == stop_addr_q);
  assign req_ready = (state_q == ST_IDLE);
  assign rd_valid  = (state_q == ST_RUN);
  assign bank_en   = rd_valid ? (NUM_BANKS'(1) << bank_q) : '0;
  assign rd_addr   = addr_q;
  assign rd_first  = rd_valid && first_q;
  assign rd_last   = rd_valid && is_final;
  assign bank_last = rd_valid && ((addr_q == ADDR_MAX) || is_final);
  assign bank_mask = mask_q;
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    addr_d      = addr_q;
    stop_bank_d = stop_bank_q;
    stop_addr_d = stop_addr_q;
    first_d     = first_q;
    mask_d      = mask_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
`ifdef FEAT_RANGE_CHECK_EN
          if (range_bad) begin
            err_d = 1'b1;
          end else
`endif
          begin
            bank_d      = lo_bank;
            addr_d      = ADDR_W'(idx_addr(32'(req_start), ADDR_W));
            stop_bank_d = hi_bank;
            stop_addr_d = ADDR_W'(idx_addr(32'(eff_stop), ADDR_W));
            mask_d      = mask_new;
            first_d     = 1'b1;
            state_d     = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (rd_ready) begin
          first_d = 1'b0;
          if (is_final) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            // Address wraps naturally; the bank steps on the same edge so crossings cost no cycle.
            addr_d = addr_q + ADDR_W'(1);
            if (addr_q == ADDR_MAX) begin
              bank_d = bank_q + BANK_W'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bank_q      <= '0;
      addr_q      <= '0;
      stop_bank_q <= '0;
      stop_addr_q <= '0;
      first_q     <= 1'b0;
      mask_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      addr_q      <= addr_d;
      stop_bank_q <= stop_bank_d;
      stop_addr_q <= stop_addr_d;
      first_q     <= first_d;
      mask_q      <= mask_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_feature_bank_sequencer.sv
// Scoreboard bench for feature_bank_sequencer at default geometry (8 banks x 512 words).
module tb_feature_bank_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_start;
  logic [11:0] req_stop;
  logic        rd_valid;
  logic        rd_ready;
  logic [7:0]  bank_en;
  logic [8:0]  rd_addr;
  logic        rd_first;
  logic        rd_last;
  logic        bank_last;
  logic [7:0]  bank_mask;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  feature_bank_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_start (req_start),
    .req_stop  (req_stop),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .bank_en   (bank_en),
    .rd_addr   (rd_addr),
    .rd_first  (rd_first),
    .rd_last   (rd_last),
    .bank_last (bank_last),
    .bank_mask (bank_mask),
    .done      (done),
    .err       (err)
  );

  typedef struct packed {
    logic [7:0] en;
    logic [8:0] addr;
    logic       first;
    logic       last;
    logic       blast;
  } word_t;

  word_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic push_range(input int start, input int stop);
    word_t w;
    for (int i = start; i <= stop; i++) begin
      w.en    = 8'd1 << (i >> 9);
      w.addr  = 9'(i & 511);
      w.first = (i == start);
      w.last  = (i == stop);
      w.blast = ((i & 511) == 511) || (i == stop);
      exp_q.push_back(w);
    end
  endtask

  // Issues one request, checks every word against the queue, and checks done timing and mask.
  task automatic run_req(input string name, input int start, input int stop, input int stall_word,
                         input int stall_len, input logic [7:0] exp_mask, input int exp_cyc);
    int cyc, widx, stalls;
    bit seen_done;
    word_t got, e;
    push_range(start, (stop >= start) ? stop : start);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s req_ready_idle got=%b exp=1", name, req_ready);
    end
    req_valid = 1'b1; req_start = 12'(start); req_stop = 12'(stop); rd_ready = 1'b1;
    cyc = 0; widx = 0; stalls = 0; seen_done = 0;
    while (cyc < 6000) begin
      @(negedge clk);
      req_valid = 1'b0;
      cyc++;
      if (done === 1'b1) begin
        seen_done = 1;
        break;
      end
      n_cmp++;
      if (rd_valid !== 1'b1) begin
        n_bad++; $display("FAIL %s rd_valid_gap cyc=%0d got=%b exp=1", name, cyc, rd_valid);
        continue;
      end
      if (exp_q.size() == 0) begin
        n_bad++; $display("FAIL %s extra_word got addr=%0d exp=none", name, rd_addr);
        rd_ready = 1'b1;
        continue;
      end
      e = exp_q[0];
      if (widx == stall_word && stalls < stall_len) begin
        rd_ready = 1'b0;
        stalls++;
        n_cmp++;
        if (bank_en !== e.en || rd_addr !== e.addr) begin
          n_bad++; $display("FAIL %s stall_hold got en=%h addr=%0d exp en=%h addr=%0d",
                            name, bank_en, rd_addr, e.en, e.addr);
        end
      end else begin
        rd_ready = 1'b1;
        got = {bank_en, rd_addr, rd_first, rd_last, bank_last};
        void'(exp_q.pop_front());
        n_cmp++;
        if (got !== e) begin
          n_bad++; $display("FAIL %s word%0d got en=%h addr=%0d f/l/bl=%b%b%b exp en=%h addr=%0d f/l/bl=%b%b%b",
                            name, widx, got.en, got.addr, got.first, got.last, got.blast,
                            e.en, e.addr, e.first, e.last, e.blast);
        end
        widx++;
      end
    end
    n_cmp++;
    if (!seen_done || cyc != exp_cyc) begin
      n_bad++; $display("FAIL %s done_cycle got=%0d seen=%0d exp=%0d", name, cyc, seen_done, exp_cyc);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL %s missing_words got_left=%0d exp=0", name, exp_q.size());
    end
    exp_q.delete();
    n_cmp++;
    if (bank_mask !== exp_mask) begin
      n_bad++; $display("FAIL %s bank_mask got=%h exp=%h", name, bank_mask, exp_mask);
    end
    n_cmp++;
    if (req_ready !== 1'b1 || bank_en !== 8'h00 || err !== 1'b0) begin
      n_bad++; $display("FAIL %s done_cycle_outputs got rdy=%b en=%h err=%b exp rdy=1 en=00 err=0",
                        name, req_ready, bank_en, err);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL %s done_pulse_width got=%b exp=0", name, done);
    end
  endtask

  task automatic check_reset_values(input string name);
    n_cmp++;
    if (req_ready !== 1'b1 || rd_valid !== 1'b0 || bank_en !== 8'h00 || rd_addr !== 9'd0 ||
        rd_first !== 1'b0 || rd_last !== 1'b0 || bank_last !== 1'b0 || bank_mask !== 8'h00 ||
        done !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL %s reset_values got rdy=%b vld=%b en=%h addr=%0d f=%b l=%b bl=%b mask=%h done=%b err=%b exp 1 0 00 0 0 0 0 00 0 0",
               name, req_ready, rd_valid, bank_en, rd_addr, rd_first, rd_last, bank_last,
               bank_mask, done, err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_start = '0; req_stop = '0; rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
  endtask

  task automatic test_single_word();
    run_req("single", 5, 5, -1, 0, 8'h01, 2);
  endtask

  task automatic test_bank_cross();
    run_req("cross", 510, 513, -1, 0, 8'h03, 5);
  endtask

  task automatic test_stall();
    run_req("stall", 1000, 1030, 9, 3, 8'h06, 35);
  endtask

  task automatic test_full_range();
    run_req("full", 0, 4095, -1, 0, 8'hFF, 4097);
  endtask

  task automatic test_reset_mid_run();
    int widx;
    @(negedge clk);
    req_valid = 1'b1; req_start = 12'd20; req_stop = 12'd40; rd_ready = 1'b1;
    widx = 0;
    for (int c = 0; c < 20 && widx < 3; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rd_valid === 1'b1) widx++;
    end
    n_cmp++;
    if (widx != 3) begin
      n_bad++; $display("FAIL midrst words_before_reset got=%0d exp=3", widx);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("midrst");
    run_req("after_rst", 7, 7, -1, 0, 8'h01, 2);
  endtask

  task automatic test_range_order();
`ifdef FEAT_RANGE_CHECK_EN
    @(negedge clk);
    req_valid = 1'b1; req_start = 12'd100; req_stop = 12'd50; rd_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if (err !== 1'b1 || rd_valid !== 1'b0) begin
      n_bad++; $display("FAIL range err_pulse got err=%b vld=%b exp err=1 vld=0", err, rd_valid);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (err !== 1'b0 || rd_valid !== 1'b0 || bank_mask !== 8'h01 || req_ready !== 1'b1) begin
        n_bad++; $display("FAIL range after_err got err=%b vld=%b mask=%h rdy=%b exp 0 0 01 1",
                          err, rd_valid, bank_mask, req_ready);
      end
    end
`else
    run_req("range", 100, 50, -1, 0, 8'h01, 2);
`endif
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_bank_cross();
    test_stall();
    test_full_range();
    test_reset_mid_run();
    test_range_order();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
